alu_operand_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the execute-stage ALU.
- Captures decoded instructions, applies operand forwarding from the EX/MEM and MEM/WB stages, and selects PC or immediate sources.
- Drives AluOperation, AluOperandA and AluOperandB to the ALU.
- Detects load-use hazards and inserts bubbles.

---
 rtl/HighLevelControl.sv | 18 +
 rtl/alu_operand_stage.sv | 210 +++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/HighLevelControl.sv
// HighLevelControl: shared control-type definitions for the execute stage.
// Provides the aluOperation encoding consumed by the ID/EX register and ALU.
package HighLevelControl;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } aluOperation;

endpackage

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register feeding the execute-stage ALU.
// Captures decoded instructions, forwards operands from EX/MEM and MEM/WB,
// selects PC/immediate sources and detects load-use hazards.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Stall, Flush          hold / squash stage contents
//   Decode*               decoded instruction and register-file read data
//   Memory*, Writeback*   producer write ports used for forwarding
//   Execute*, Alu*        registered instruction fields and forwarded operands
//   LoadUseStall          combinational request to hold decode/fetch
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module alu_operand_stage #(
    parameter int BIT_COUNT      = `BIT_COUNT,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic                          DecodeValid,
    input  HighLevelControl::aluOperation DecodeAluOperation,
    input  logic [REG_ADDR_WIDTH-1:0]     DecodeRs1Addr,
    input  logic [REG_ADDR_WIDTH-1:0]     DecodeRs2Addr,
    input  logic                          DecodeUsesRs1,
    input  logic                          DecodeUsesRs2,
    input  logic [BIT_COUNT-1:0]          DecodeRs1Data,
    input  logic [BIT_COUNT-1:0]          DecodeRs2Data,
    input  logic [BIT_COUNT-1:0]          DecodeImmediate,
    input  logic [BIT_COUNT-1:0]          DecodePc,
    input  logic                          DecodeUseImmediate,
    input  logic                          DecodeUsePc,
    input  logic [REG_ADDR_WIDTH-1:0]     DecodeRdAddr,
    input  logic                          DecodeRegWrite,
    input  logic                          DecodeIsLoad,
    input  logic                          MemoryRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0]     MemoryRdAddr,
    input  logic [BIT_COUNT-1:0]          MemoryResult,
    input  logic                          WritebackRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0]     WritebackRdAddr,
    input  logic [BIT_COUNT-1:0]          WritebackResult,
    output logic                          ExecuteValid,
    output HighLevelControl::aluOperation AluOperation,
    output logic [BIT_COUNT-1:0]          AluOperandA,
    output logic [BIT_COUNT-1:0]          AluOperandB,
    output logic [BIT_COUNT-1:0]          ExecuteStoreData,
    output logic [REG_ADDR_WIDTH-1:0]     ExecuteRdAddr,
    output logic                          ExecuteRegWrite,
    output logic                          ExecuteIsLoad,
    output logic                          LoadUseStall
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [BIT_COUNT-1:0]      DATA_ZERO = {BIT_COUNT{1'b0}};

    // Stage state
    logic                          valid_q,     valid_d;
    HighLevelControl::aluOperation alu_op_q,    alu_op_d;
    logic [REG_ADDR_WIDTH-1:0]     rs1_addr_q,  rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0]     rs2_addr_q,  rs2_addr_d;
    logic [BIT_COUNT-1:0]          rs1_data_q,  rs1_data_d;
    logic [BIT_COUNT-1:0]          rs2_data_q,  rs2_data_d;
    logic [BIT_COUNT-1:0]          imm_q,       imm_d;
    logic [BIT_COUNT-1:0]          pc_q,        pc_d;
    logic                          use_imm_q,   use_imm_d;
    logic                          use_pc_q,    use_pc_d;
    logic [REG_ADDR_WIDTH-1:0]     rd_addr_q,   rd_addr_d;
    logic                          reg_write_q, reg_write_d;
    logic                          is_load_q,   is_load_d;

    logic [BIT_COUNT-1:0]          rs1_fwd_s;
    logic [BIT_COUNT-1:0]          rs2_fwd_s;
    logic                          load_use_s;

    // Forwarded value of a stored source: x0 is hard zero, MEM beats WB.
    function automatic logic [BIT_COUNT-1:0] forward_operand(
        input logic [REG_ADDR_WIDTH-1:0] src_addr,
        input logic [BIT_COUNT-1:0]      stored_data
    );
        logic [BIT_COUNT-1:0] result;
        if (src_addr == REG_ZERO) begin
            result = DATA_ZERO;
        end else if (MemoryRegWrite && (MemoryRdAddr == src_addr)) begin
            result = MemoryResult;
        end else if (WritebackRegWrite && (WritebackRdAddr == src_addr)) begin
            result = WritebackResult;
        end else begin
            result = stored_data;
        end
        return result;
    endfunction

    // Register-file read data at capture: the register file is written at the
    // same edge we sample it, so a retiring WB write must be bypassed in.
    function automatic logic [BIT_COUNT-1:0] capture_operand(
        input logic [REG_ADDR_WIDTH-1:0] src_addr,
        input logic [BIT_COUNT-1:0]      rf_data
    );
        logic [BIT_COUNT-1:0] result;
        if (WritebackRegWrite && (src_addr != REG_ZERO) && (WritebackRdAddr == src_addr)) begin
            result = WritebackResult;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    // Zero-cycle forwarding of the stored sources.
    always_comb begin
        rs1_fwd_s = forward_operand(rs1_addr_q, rs1_data_q);
        rs2_fwd_s = forward_operand(rs2_addr_q, rs2_data_q);
    end

    // Load-use hazard: the instruction in decode needs a load still in execute.
    always_comb begin
        load_use_s = DecodeValid & valid_q & is_load_q & (rd_addr_q != REG_ZERO) &
                     ((DecodeUsesRs1 & (DecodeRs1Addr == rd_addr_q)) |
                      (DecodeUsesRs2 & (DecodeRs2Addr == rd_addr_q))) & ~Flush;
    end

    // Next-state selection: reset > Flush > Stall > load-use bubble > load.
    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        use_imm_d   = use_imm_q;
        use_pc_d    = use_pc_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        is_load_d   = is_load_q;
        if (reset) begin
            valid_d     = 1'b0;
            alu_op_d    = HighLevelControl::ADD;
            rs1_addr_d  = REG_ZERO;
            rs2_addr_d  = REG_ZERO;
            rs1_data_d  = DATA_ZERO;
            rs2_data_d  = DATA_ZERO;
            imm_d       = DATA_ZERO;
            pc_d        = DATA_ZERO;
            use_imm_d   = 1'b0;
            use_pc_d    = 1'b0;
            rd_addr_d   = REG_ZERO;
            reg_write_d = 1'b0;
            is_load_d   = 1'b0;
        end else if (Flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            is_load_d   = 1'b0;
        end else if (Stall) begin
            // Latch forwarded values so a producer retiring mid-stall is kept.
            rs1_data_d  = rs1_fwd_s;
            rs2_data_d  = rs2_fwd_s;
        end else if (load_use_s) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else begin
            valid_d     = DecodeValid;
            alu_op_d    = DecodeAluOperation;
            rs1_addr_d  = DecodeRs1Addr;
            rs2_addr_d  = DecodeRs2Addr;
            rs1_data_d  = capture_operand(DecodeRs1Addr, DecodeRs1Data);
            rs2_data_d  = capture_operand(DecodeRs2Addr, DecodeRs2Data);
            imm_d       = DecodeImmediate;
            pc_d        = DecodePc;
            use_imm_d   = DecodeUseImmediate;
            use_pc_d    = DecodeUsePc;
            rd_addr_d   = DecodeRdAddr;
            reg_write_d = DecodeRegWrite;
            is_load_d   = DecodeIsLoad;
        end
    end

    // Stage register; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        alu_op_q    <= alu_op_d;
        rs1_addr_q  <= rs1_addr_d;
        rs2_addr_q  <= rs2_addr_d;
        rs1_data_q  <= rs1_data_d;
        rs2_data_q  <= rs2_data_d;
        imm_q       <= imm_d;
        pc_q        <= pc_d;
        use_imm_q   <= use_imm_d;
        use_pc_q    <= use_pc_d;
        rd_addr_q   <= rd_addr_d;
        reg_write_q <= reg_write_d;
        is_load_q   <= is_load_d;
    end

    // Output drive.
    always_comb begin
        ExecuteValid     = valid_q;
        AluOperation     = alu_op_q;
        AluOperandA      = use_pc_q  ? pc_q  : rs1_fwd_s;
        AluOperandB      = use_imm_q ? imm_q : rs2_fwd_s;
        ExecuteStoreData = rs2_fwd_s;
        ExecuteRdAddr    = rd_addr_q;
        ExecuteRegWrite  = reg_write_q;
        ExecuteIsLoad    = is_load_q;
        LoadUseStall     = load_use_s;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage
// (32-bit datapath). Inputs change 1 time unit after a rising edge; outputs
// are checked in the same window, away from the edge.
module tb_alu_operand_stage;

    localparam int W = 32;
    localparam int A = 5;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          Stall, Flush;
    logic                          DecodeValid;
    HighLevelControl::aluOperation DecodeAluOperation;
    logic [A-1:0]                  DecodeRs1Addr, DecodeRs2Addr;
    logic                          DecodeUsesRs1, DecodeUsesRs2;
    logic [W-1:0]                  DecodeRs1Data, DecodeRs2Data;
    logic [W-1:0]                  DecodeImmediate, DecodePc;
    logic                          DecodeUseImmediate, DecodeUsePc;
    logic [A-1:0]                  DecodeRdAddr;
    logic                          DecodeRegWrite, DecodeIsLoad;
    logic                          MemoryRegWrite;
    logic [A-1:0]                  MemoryRdAddr;
    logic [W-1:0]                  MemoryResult;
    logic                          WritebackRegWrite;
    logic [A-1:0]                  WritebackRdAddr;
    logic [W-1:0]                  WritebackResult;
    logic                          ExecuteValid;
    HighLevelControl::aluOperation AluOperation;
    logic [W-1:0]                  AluOperandA, AluOperandB, ExecuteStoreData;
    logic [A-1:0]                  ExecuteRdAddr;
    logic                          ExecuteRegWrite, ExecuteIsLoad;
    logic                          LoadUseStall;

    int checks = 0;
    int errors = 0;

    alu_operand_stage #(.BIT_COUNT(W), .REG_ADDR_WIDTH(A)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .DecodeValid(DecodeValid), .DecodeAluOperation(DecodeAluOperation),
        .DecodeRs1Addr(DecodeRs1Addr), .DecodeRs2Addr(DecodeRs2Addr),
        .DecodeUsesRs1(DecodeUsesRs1), .DecodeUsesRs2(DecodeUsesRs2),
        .DecodeRs1Data(DecodeRs1Data), .DecodeRs2Data(DecodeRs2Data),
        .DecodeImmediate(DecodeImmediate), .DecodePc(DecodePc),
        .DecodeUseImmediate(DecodeUseImmediate), .DecodeUsePc(DecodeUsePc),
        .DecodeRdAddr(DecodeRdAddr), .DecodeRegWrite(DecodeRegWrite),
        .DecodeIsLoad(DecodeIsLoad),
        .MemoryRegWrite(MemoryRegWrite), .MemoryRdAddr(MemoryRdAddr),
        .MemoryResult(MemoryResult),
        .WritebackRegWrite(WritebackRegWrite), .WritebackRdAddr(WritebackRdAddr),
        .WritebackResult(WritebackResult),
        .ExecuteValid(ExecuteValid), .AluOperation(AluOperation),
        .AluOperandA(AluOperandA), .AluOperandB(AluOperandB),
        .ExecuteStoreData(ExecuteStoreData), .ExecuteRdAddr(ExecuteRdAddr),
        .ExecuteRegWrite(ExecuteRegWrite), .ExecuteIsLoad(ExecuteIsLoad),
        .LoadUseStall(LoadUseStall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a decoded instruction into the decode slot.
    task automatic decode(input HighLevelControl::aluOperation op,
                          input logic [A-1:0] rd, input logic [A-1:0] rs1, input logic [A-1:0] rs2,
                          input logic [W-1:0] d1, input logic [W-1:0] d2,
                          input logic load);
        DecodeValid        = 1'b1;
        DecodeAluOperation = op;
        DecodeRdAddr       = rd;
        DecodeRs1Addr      = rs1;
        DecodeRs2Addr      = rs2;
        DecodeRs1Data      = d1;
        DecodeRs2Data      = d2;
        DecodeUsesRs1      = 1'b1;
        DecodeUsesRs2      = 1'b1;
        DecodeRegWrite     = 1'b1;
        DecodeIsLoad       = load;
        DecodeUseImmediate = 1'b0;
        DecodeUsePc        = 1'b0;
        DecodeImmediate    = 32'h0;
        DecodePc           = 32'h0;
    endtask

    task automatic clear_producers();
        MemoryRegWrite    = 1'b0;
        MemoryRdAddr      = 5'd0;
        MemoryResult      = 32'h0;
        WritebackRegWrite = 1'b0;
        WritebackRdAddr   = 5'd0;
        WritebackResult   = 32'h0;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        clear_producers();
        decode(HighLevelControl::ADD, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0);

        // Reset held two cycles while decode offers an instruction.
        step(); step();
        check("rst_valid", ExecuteValid, 1'b0);
        check("rst_op", AluOperation, HighLevelControl::ADD);
        check("rst_opa", AluOperandA, 32'h0);
        check("rst_opb", AluOperandB, 32'h0);
        check("rst_rd", ExecuteRdAddr, 5'd0);
        check("rst_regwrite", ExecuteRegWrite, 1'b0);

        // First edge after reset loads ADD x3,x1,x2.
        reset = 1'b0;
        step();
        check("load_valid", ExecuteValid, 1'b1);
        check("load_rd", ExecuteRdAddr, 5'd3);
        check("load_opa", AluOperandA, 32'd5);
        check("load_opb", AluOperandB, 32'd7);
        check("load_store", ExecuteStoreData, 32'd7);

        // MEM and WB both produce x1: MEM wins.
        DecodeValid = 1'b0;
        MemoryRegWrite = 1'b1; MemoryRdAddr = 5'd1; MemoryResult = 32'd100;
        WritebackRegWrite = 1'b1; WritebackRdAddr = 5'd1; WritebackResult = 32'd50;
        #1;
        check("fwd_mem_prio", AluOperandA, 32'd100);
        check("fwd_opb_plain", AluOperandB, 32'd7);
        MemoryRegWrite = 1'b0;
        #1;
        check("fwd_wb_only", AluOperandA, 32'd50);
        MemoryRegWrite = 1'b1; MemoryRdAddr = 5'd0;
        #1;
        check("fwd_mem_rd0_ignored", AluOperandA, 32'd50);
        clear_producers();

        // Execute holds LW x4; decode ADD x5,x4,x6 -> load-use bubble.
        decode(HighLevelControl::ADD, 5'd4, 5'd1, 5'd0, 32'd9, 32'd0, 1'b1);
        step();
        check("lw_isload", ExecuteIsLoad, 1'b1);
        decode(HighLevelControl::ADD, 5'd5, 5'd4, 5'd6, 32'd1, 32'd2, 1'b0);
        #1;
        check("lu_stall", LoadUseStall, 1'b1);
        step();
        check("lu_bubble_valid", ExecuteValid, 1'b0);
        check("lu_bubble_regwrite", ExecuteRegWrite, 1'b0);
        check("lu_release", LoadUseStall, 1'b0);
        step();
        check("lu_reload_valid", ExecuteValid, 1'b1);
        check("lu_reload_rd", ExecuteRdAddr, 5'd5);

        // Load to x0 never creates a hazard.
        decode(HighLevelControl::ADD, 5'd0, 5'd1, 5'd0, 32'd9, 32'd0, 1'b1);
        step();
        decode(HighLevelControl::ADD, 5'd5, 5'd0, 5'd6, 32'd0, 32'd2, 1'b0);
        #1;
        check("lu_x0_nostall", LoadUseStall, 1'b0);

        // Flush masks a load-use match and squashes the stage.
        decode(HighLevelControl::ADD, 5'd4, 5'd1, 5'd0, 32'd9, 32'd0, 1'b1);
        step();
        decode(HighLevelControl::SUB, 5'd5, 5'd6, 5'd4, 32'd1, 32'd2, 1'b0);
        #1;
        check("lu_pre_flush", LoadUseStall, 1'b1);
        Flush = 1'b1;
        #1;
        check("lu_flush_masked", LoadUseStall, 1'b0);
        step();
        check("flush_valid", ExecuteValid, 1'b0);
        check("flush_isload", ExecuteIsLoad, 1'b0);
        Flush = 1'b0;

        // Flush together with Stall still squashes.
        decode(HighLevelControl::OR, 5'd9, 5'd1, 5'd2, 32'd1, 32'd2, 1'b0);
        step();
        check("pre_fs_valid", ExecuteValid, 1'b1);
        Flush = 1'b1; Stall = 1'b1;
        step();
        check("flush_stall_valid", ExecuteValid, 1'b0);
        check("flush_stall_regwrite", ExecuteRegWrite, 1'b0);
        Flush = 1'b0; Stall = 1'b0;

        // Stall 3 cycles; WB delivers x2=0xDEAD in the first, then retires.
        decode(HighLevelControl::AND, 5'd8, 5'd1, 5'd2, 32'd3, 32'd0, 1'b0);
        step();
        check("stall_pre_opb", AluOperandB, 32'h0);
        decode(HighLevelControl::XOR, 5'd11, 5'd12, 5'd13, 32'd0, 32'd0, 1'b0);
        Stall = 1'b1;
        WritebackRegWrite = 1'b1; WritebackRdAddr = 5'd2; WritebackResult = 32'hDEAD;
        #1;
        check("stall_c1_opb", AluOperandB, 32'hDEAD);
        step();
        clear_producers();
        #1;
        check("stall_c2_opb", AluOperandB, 32'hDEAD);
        step();
        step();
        Stall = 1'b0;
        DecodeValid = 1'b0;
        #1;
        check("stall_after_opb", AluOperandB, 32'hDEAD);
        check("stall_held_rd", ExecuteRdAddr, 5'd8);
        check("stall_held_op", AluOperation, HighLevelControl::AND);

        // Capture bypass: stale register-file read of x7 replaced by WB.
        decode(HighLevelControl::ADD, 5'd10, 5'd7, 5'd0, 32'd0, 32'd0, 1'b0);
        WritebackRegWrite = 1'b1; WritebackRdAddr = 5'd7; WritebackResult = 32'h1234;
        step();
        clear_producers();
        #1;
        check("capture_bypass", AluOperandA, 32'h1234);

        // x0 always reads zero, even if the read data is non-zero.
        decode(HighLevelControl::ADD, 5'd10, 5'd0, 5'd0, 32'h99, 32'h0, 1'b0);
        WritebackRegWrite = 1'b1; WritebackRdAddr = 5'd0; WritebackResult = 32'h55;
        step();
        clear_producers();
        #1;
        check("x0_zero", AluOperandA, 32'h0);

        // PC and immediate source selects.
        decode(HighLevelControl::ADD, 5'd10, 5'd1, 5'd2, 32'd5, 32'd6, 1'b0);
        DecodeUsePc = 1'b1; DecodePc = 32'h80;
        DecodeUseImmediate = 1'b1; DecodeImmediate = 32'h44;
        step();
        check("use_pc", AluOperandA, 32'h80);
        check("use_imm", AluOperandB, 32'h44);
        check("imm_store", ExecuteStoreData, 32'd6);

        // Reset while a load-use hazard is pending: stall drops after reset.
        decode(HighLevelControl::ADD, 5'd4, 5'd1, 5'd0, 32'd9, 32'd0, 1'b1);
        step();
        decode(HighLevelControl::ADD, 5'd5, 5'd4, 5'd6, 32'd1, 32'd2, 1'b0);
        reset = 1'b1;
        step();
        check("rst_mid_lu_valid", ExecuteValid, 1'b0);
        check("rst_mid_lu_stall", LoadUseStall, 1'b0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
